sram_responder: RTL and testbench

- Memory-side responder for the active-low SRAM control protocol that the board-level sequencer drives (nMemOut = output enable, nMemWrite = write enable, address, data).
- Stores 128 x 32-bit words and answers reads with registered data plus a valid strobe.
- Clears itself after reset and flags illegal control combinations.
- Sits between the top-level sequencer and the register file. Its rdata/rvalid feed the register-file write port.

---
 rtl/sram_pkg.sv | 11 +
 rtl/sram_array.sv | 23 ++
 rtl/sram_responder.sv | 68 ++++++
 tb/tb_sram_responder.sv | 136 +++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared widths, FSM states and decoded access ops for the SRAM responder
package sram_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 7;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int ERR_W  = 8;

   typedef enum logic {INIT, READY} state_t;

   typedef enum logic [1:0] {OP_IDLE, OP_WR, OP_RD, OP_CONFLICT} op_t;
endpackage

// File: rtl/sram_array.sv
// sram_array: DEPTH x DATA_W storage with one synchronous write and one synchronous read port
module sram_array
   import sram_pkg::*;
#(
   parameter int DW = DATA_W,
   parameter int AW = ADDR_W
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AW];

   // storage is deliberately unreset; the responder clears it word by word after reset
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: active-low SRAM protocol responder with power-on clear and conflict counting
module sram_responder
   import sram_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              nOE,
   input  logic              nWE,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              ready,
   output logic              conflict,
   output logic [ERR_W-1:0]  err_cnt
);
   state_t            state;
   op_t               op;
   logic [ADDR_W-1:0] clr;
   logic [DATA_W-1:0] arr_q;
   logic [DATA_W-1:0] hold;

   // decode the control pins; everything is ignored until the clear finishes
   always_comb
      op = (state != READY)   ? OP_IDLE :
           (!nOE && !nWE)     ? OP_CONFLICT :
           !nOE               ? OP_RD :
           !nWE               ? OP_WR : OP_IDLE;

   sram_array u_array (
      .clk   (clk),
      .we    (state == INIT || op == OP_WR),
      .waddr (state == INIT ? clr : addr),
      .wdata (state == INIT ? '0 : wdata),
      .re    (op == OP_RD),
      .raddr (addr),
      .rdata (arr_q)
   );

   // the array read register has no reset, so rdata shows it only while fresh and
   // otherwise a resettable copy of the last result
   assign rdata = rvalid ? arr_q : hold;
   assign ready = (state == READY);

   // FSM, clear counter, strobes, error counter and read-data hold register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= INIT;
         clr      <= '0;
         rvalid   <= 1'b0;
         conflict <= 1'b0;
         err_cnt  <= '0;
         hold     <= '0;
      end else begin
         if (rvalid) hold <= arr_q;
         rvalid   <= (op == OP_RD);
         conflict <= (op == OP_CONFLICT);
         if (op == OP_CONFLICT && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
         case (state)
            INIT: begin
               clr <= clr + ADDR_W'(1);
               if (clr == ADDR_W'(DEPTH - 1)) state <= READY;
            end
            default: state <= READY;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: scoreboard bench for sram_responder with a cycle-level reference model
module tb_sram_responder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        nOE = 1'b1;
   logic        nWE = 1'b1;
   logic [6:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        rvalid;
   logic        ready;
   logic        conflict;
   logic [7:0]  err_cnt;

   sram_responder dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .nOE      (nOE),
      .nWE      (nWE),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .rvalid   (rvalid),
      .ready    (ready),
      .conflict (conflict),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [31:0] mem_m [128];
   logic [31:0] q [$];
   logic [31:0] last = '0;
   logic        m_rdy = 1'b0;
   int          m_cnt = 0;
   int          m_err = 0;
   logic        exp_rv = 1'b0;
   logic        exp_conf = 1'b0;
   logic        mon_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   // drive one cycle from negedge+1, update the model for the coming posedge
   task automatic step(input logic oe, input logic we, input logic [6:0] a, input logic [31:0] d);
      nOE = oe; nWE = we; addr = a; wdata = d;
      exp_rv = 1'b0; exp_conf = 1'b0;
      if (m_rdy) begin
         if (!oe && we) begin q.push_back(mem_m[a]); exp_rv = 1'b1; end
         else if (oe && !we) mem_m[a] = d;
         else if (!oe && !we) begin exp_conf = 1'b1; if (m_err != 255) m_err++; end
      end else begin
         m_cnt++;
         if (m_cnt == 128) m_rdy = 1'b1;
      end
      @(negedge clk); #1;
   endtask

   // assert reset asynchronously, check outputs at once, hold across one edge, release
   task automatic do_reset();
      mon_en = 1'b0;
      rst_n = 1'b0;
      nOE = 1'b1; nWE = 1'b1;
      #1;
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_ready", ready, 0);
      chk("rst_conflict", conflict, 0);
      chk("rst_err_cnt", err_cnt, 0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      foreach (mem_m[i]) mem_m[i] = '0;
      q.delete();
      last = '0; m_rdy = 1'b0; m_cnt = 0; m_err = 0; exp_rv = 1'b0; exp_conf = 1'b0;
      mon_en = 1'b1;
   endtask

   // compare every DUT output against the model each cycle
   always @(negedge clk) begin
      if (mon_en) begin
         chk("rvalid", rvalid, exp_rv);
         chk("conflict", conflict, exp_conf);
         chk("ready", ready, m_rdy);
         chk("err_cnt", err_cnt, m_err);
         if (exp_rv && q.size() > 0) last = q.pop_front();
         chk("rdata", rdata, last);
      end
   end

   initial begin
      #1;
      // 1: power-on clear, ready after exactly 128 cycles, reads of cleared words
      do_reset();
      for (int i = 0; i < 128; i++) step(1, 1, 7'd0, 32'd0);
      step(0, 1, 7'd0, 0);   step(1, 1, 0, 0);
      step(0, 1, 7'd64, 0);  step(1, 1, 0, 0);
      step(0, 1, 7'd127, 0); step(1, 1, 0, 0);
      // 2: descending pattern, back-to-back reads
      for (int i = 0; i < 128; i++) step(1, 0, 7'(i), 32'(127 - i));
      for (int i = 0; i < 128; i++) step(0, 1, 7'(i), 32'h0);
      step(1, 1, 0, 0);
      // 3: write then immediate read, then idle hold
      step(1, 0, 7'd5, 32'hDEADBEEF);
      step(0, 1, 7'd5, 0);
      step(1, 1, 0, 0); step(1, 1, 0, 0);
      // 127 -> 0 are independent words
      step(1, 0, 7'd127, 32'h11111111);
      step(1, 0, 7'd0, 32'h22222222);
      step(0, 1, 7'd127, 0); step(0, 1, 7'd0, 0); step(1, 1, 0, 0);
      // 4: conflict leaves the word untouched, counter saturates
      step(0, 0, 7'd9, 32'h12345678);
      step(1, 1, 0, 0);
      step(0, 1, 7'd9, 0); step(1, 1, 0, 0);
      for (int i = 0; i < 300; i++) step(0, 0, 7'd9, 32'h12345678);
      step(1, 1, 0, 0); step(1, 1, 0, 0);
      // 5: activity during INIT is ignored, every word cleared
      do_reset();
      for (int i = 0; i < 128; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom), $urandom);
      for (int i = 0; i < 128; i++) step(0, 1, 7'(i), 0);
      step(1, 1, 0, 0);
      // 6: reset while a read result is on the outputs
      step(1, 0, 7'd3, 32'hA5A5A5A5);
      step(0, 1, 7'd3, 0);
      do_reset();
      for (int i = 0; i < 128; i++) step(1, 1, 0, 0);
      step(0, 1, 7'd3, 0); step(1, 1, 0, 0);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
